entrada_pico_gen: RTL and testbench
===================================

ENTRADA_PICO_GEN -- requirements
Module: entrada_pico_gen

Interface
REQ-001 Parameter NREG, 9, number of RTC capture registers (1..16).
REQ-002 Parameter DW, 8, data width of RTC bus, key code and read port.
REQ-003 Parameter KEY_DEPTH, 4, key FIFO depth; power of two, 2..16.
REQ-004 Parameter ID_BASE, 8'h00, port_id of capture register 0; register i at ID_BASE+i.
REQ-005 Parameter ID_KEY, 8'h10, port_id of key FIFO head (pop on read).
REQ-006 Parameter ID_STATUS, 8'h11, port_id of key FIFO status.
REQ-007 clk  input  1  single system clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 LL_signal  input  1  RTC read-latch strobe; capture enable.
REQ-010 reg_select  input  4  index of capture register to load.
REQ-011 RTC_BUS  input  DW  RTC data bus sampled on capture.
REQ-012 tecla  input  DW  key code.
REQ-013 tecla_valid  input  1  one-cycle push strobe for tecla.
REQ-014 id_port  input  8  processor port_id.
REQ-015 read_strobe  input  1  processor read strobe, one cycle.
REQ-016 dato_inpico  output  DW  registered read data to processor.
REQ-017 key_full  output  1  key FIFO full.
REQ-018 key_overflow  output  1  sticky overflow flag.

Function
REQ-019 When LL_signal=1 and reg_select<NREG, live register[reg_select] SHALL load RTC_BUS at the edge; reg_select>=NREG SHALL load nothing.
REQ-020 dato_inpico SHALL be registered: value at edge n+1 reflects id_port and state at cycle n (latency 1).
REQ-021 Read map: ID_BASE+i (i<NREG) -> register i; ID_KEY -> FIFO head or 0 if empty; ID_STATUS -> {overflow, full, empty, count[4:0]} for DW=8 (LSB-aligned, zero-filled for DW>8); any other id_port -> 0.
REQ-022 tecla_valid=1 with FIFO not full SHALL write tecla at tail and increment count.
REQ-023 tecla_valid=1 with FIFO full and no pop SHALL drop tecla and set key_overflow.
REQ-024 read_strobe=1 with id_port=ID_KEY and FIFO non-empty SHALL pop head; with empty FIFO SHALL do nothing.
REQ-025 Simultaneous push and pop when full SHALL perform both, count unchanged, no overflow; when empty SHALL push only.
REQ-026 Pointers SHALL wrap modulo KEY_DEPTH; count range 0..KEY_DEPTH.
REQ-027 read_strobe=1 with id_port=ID_STATUS SHALL clear key_overflow; a same-cycle overflow event SHALL win (flag stays 1).
REQ-028 key_full SHALL equal (count==KEY_DEPTH), combinational from state.
REQ-029 Capture and FIFO activity in the same cycle SHALL be independent.

Reset
REQ-030 reset=0 SHALL immediately clear all capture and shadow registers, FIFO pointers, count, key_overflow and dato_inpico to 0; key_full=0.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents; first push after release lands at slot 0.

Configuration
REQ-032 Macro ENTRADA_PICO_SNAPSHOT_EN defined: read_strobe with id_port=ID_BASE SHALL copy all live registers into a shadow bank in that cycle; reads of ID_BASE+1..ID_BASE+NREG-1 return shadow; ID_BASE returns live.
REQ-033 Macro undefined: no shadow bank; all register reads return live values.

Verification
REQ-034 Reset, LL_signal=1, reg_select=2, RTC_BUS=8'h45; then id_port=ID_BASE+2 -> dato_inpico=8'h45 one cycle later; reg_select=12 write -> all registers unchanged.
REQ-035 Push 8'h0A,8'h0B; read ID_KEY with strobe twice -> 8'h0A then 8'h0B; third read -> 8'h00, status empty=1, count=0.
REQ-036 Push 5 keys into depth 4 -> key_full=1, key_overflow=1, status=8'hC4; read ID_STATUS with strobe -> key_overflow=0.
REQ-037 Full FIFO, push 8'h77 and pop same cycle -> count stays 4, overflow 0, 8'h77 read last after three more pops.
REQ-038 SNAPSHOT_EN: reg1=8'h30, read ID_BASE with strobe, then load reg1=8'h31 -> read ID_BASE+1 returns 8'h30; without macro returns 8'h31.
REQ-039 Assert reset with 3 keys queued -> count=0, dato_inpico=0 immediately; push 8'h22, read -> 8'h22.

Source files
------------

// File: rtl/entrada_pico_gen_if.sv
// Bus bundle between the processor/RTC/keypad side and entrada_pico_gen.
// The master side drives captures, key pushes and read requests; the slave
// side (the input block) returns read data and key FIFO flags.
interface entrada_pico_gen_if #(
  parameter int DW = 8
);
  logic          LL_signal;
  logic [3:0]    reg_select;
  logic [DW-1:0] RTC_BUS;
  logic [DW-1:0] tecla;
  logic          tecla_valid;
  logic [7:0]    id_port;
  logic          read_strobe;
  logic [DW-1:0] dato_inpico;
  logic          key_full;
  logic          key_overflow;

  modport master (
    output LL_signal, reg_select, RTC_BUS, tecla, tecla_valid, id_port, read_strobe,
    input  dato_inpico, key_full, key_overflow
  );

  modport slave (
    input  LL_signal, reg_select, RTC_BUS, tecla, tecla_valid, id_port, read_strobe,
    output dato_inpico, key_full, key_overflow
  );
endinterface

// File: rtl/entrada_pico_gen.sv
// Processor input block: RTC capture registers, a small key FIFO and a
// registered read port addressed by port_id.
// Optional feature: define ENTRADA_PICO_SNAPSHOT_EN to add a shadow bank that
// freezes all capture registers when register 0 is read, so a multi-byte RTC
// value read over several cycles stays coherent.
module entrada_pico_gen #(
  parameter int         NREG      = 9,
  parameter int         DW        = 8,
  parameter int         KEY_DEPTH = 4,
  parameter logic [7:0] ID_BASE   = 8'h00,
  parameter logic [7:0] ID_KEY    = 8'h10,
  parameter logic [7:0] ID_STATUS = 8'h11
) (
  input logic               clk,
  input logic               reset,
  entrada_pico_gen_if.slave pico
);

  localparam int AW = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;

  logic [DW-1:0] live [NREG];
  logic [DW-1:0] mem  [KEY_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic [DW-1:0] dato;
  logic [DW-1:0] rd_data;
  logic [7:0]    status8;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          ovf_event;
  logic          status_rd;

  assign empty     = (count == 5'd0);
  assign full      = (count == 5'(KEY_DEPTH));
  assign pop       = pico.read_strobe && (pico.id_port == ID_KEY) && !empty;
  // A full FIFO still accepts a key when the head leaves in the same cycle.
  assign push      = pico.tecla_valid && (!full || pop);
  assign ovf_event = pico.tecla_valid && full && !pop;
  assign status_rd = pico.read_strobe && (pico.id_port == ID_STATUS);
  assign status8   = {overflow, full, empty, count};

  assign pico.dato_inpico  = dato;
  assign pico.key_full     = full;
  assign pico.key_overflow = overflow;

`ifdef ENTRADA_PICO_SNAPSHOT_EN
  logic [DW-1:0] shadow [NREG];

  // Freeze every live register into the shadow bank when register 0 is read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (pico.read_strobe && (pico.id_port == ID_BASE)) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= live[i];
    end
  end
`endif

  // Capture RTC_BUS into the selected register; out-of-range selects are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) live[i] <= '0;
    end else if (pico.LL_signal) begin
      for (int i = 0; i < NREG; i++) begin
        if (pico.reg_select == 4'(i)) live[i] <= pico.RTC_BUS;
      end
    end
  end

  // Key FIFO storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KEY_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pico.tecla;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a status read keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (status_rd) begin
      overflow <= 1'b0;
    end
  end

  // Read map decode from the current (pre-edge) state.
  always_comb begin
    rd_data = '0;
    if (pico.id_port == ID_KEY) begin
      rd_data = empty ? '0 : mem[rd_ptr];
    end else if (pico.id_port == ID_STATUS) begin
      rd_data = DW'(status8);
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (pico.id_port == 8'(ID_BASE + 8'(i))) begin
`ifdef ENTRADA_PICO_SNAPSHOT_EN
          rd_data = (i == 0) ? live[i] : shadow[i];
`else
          rd_data = live[i];
`endif
        end
      end
    end
  end

  // One-cycle registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dato <= '0;
    end else begin
      dato <= rd_data;
    end
  end

endmodule

// File: tb/tb_entrada_pico_gen.sv
module tb_entrada_pico_gen;
  localparam int         NREG = 9;
  localparam int         KD   = 4;
  localparam logic [7:0] IDB  = 8'h00;
  localparam logic [7:0] IDK  = 8'h10;
  localparam logic [7:0] IDS  = 8'h11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  entrada_pico_gen_if #(.DW(8)) pif ();

  entrada_pico_gen #(
    .NREG(NREG), .DW(8), .KEY_DEPTH(KD),
    .ID_BASE(IDB), .ID_KEY(IDK), .ID_STATUS(IDS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pico(pif.slave)
  );

  // Behavioural model: register array, key queue, sticky flag, expected read.
  logic [7:0] m_live   [NREG];
  logic [7:0] m_shadow [NREG];
  logic [7:0] m_q [$];
  logic       m_ovf  = 1'b0;
  logic [7:0] m_dato = 8'h00;

  function automatic logic [7:0] m_read(input logic [7:0] id);
    int idx;
    idx = int'(id) - int'(IDB);
    if (id == IDK) return (m_q.size() > 0) ? m_q[0] : 8'h00;
    if (id == IDS) return {m_ovf, (m_q.size() == KD), (m_q.size() == 0), 5'(m_q.size())};
    if (idx >= 0 && idx < NREG) begin
`ifdef ENTRADA_PICO_SNAPSHOT_EN
      if (idx != 0) return m_shadow[idx];
`endif
      return m_live[idx];
    end
    return 8'h00;
  endfunction

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_live[i] = 8'h00;
      m_shadow[i] = 8'h00;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_live[i] = 8'h00;
        m_shadow[i] = 8'h00;
      end
      m_q.delete();
      m_ovf  = 1'b0;
      m_dato = 8'h00;
    end else begin
      bit do_pop;
      bit full_now;
      m_dato   = m_read(pif.id_port);
      full_now = (m_q.size() == KD);
      do_pop   = pif.read_strobe && (pif.id_port == IDK) && (m_q.size() > 0);
`ifdef ENTRADA_PICO_SNAPSHOT_EN
      if (pif.read_strobe && pif.id_port == IDB)
        for (int i = 0; i < NREG; i++) m_shadow[i] = m_live[i];
`endif
      if (pif.LL_signal && int'(pif.reg_select) < NREG) m_live[pif.reg_select] = pif.RTC_BUS;
      if (pif.read_strobe && pif.id_port == IDS) m_ovf = 1'b0;
      if (pif.tecla_valid && full_now && !do_pop) m_ovf = 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (pif.tecla_valid && (m_q.size() < KD)) m_q.push_back(pif.tecla);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_dato", pif.dato_inpico, m_dato);
    chk("model_full", 8'(pif.key_full), 8'(m_q.size() == KD));
    chk("model_ovf", 8'(pif.key_overflow), 8'(m_ovf));
  end

  task automatic idle();
    pif.LL_signal = 1'b0; pif.reg_select = 4'd0; pif.RTC_BUS = 8'h00;
    pif.tecla = 8'h00; pif.tecla_valid = 1'b0; pif.id_port = 8'hFF; pif.read_strobe = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] keys [5];
    idle();
    reset = 1'b0;
    cyc(); cyc();
    chk("reset_dato", pif.dato_inpico, 8'h00);
    chk("reset_full", 8'(pif.key_full), 8'h00);
    reset = 1'b1;
    cyc();

    // Capture register 2 and read it back; out-of-range select writes nothing.
    pif.LL_signal = 1'b1; pif.reg_select = 4'd2; pif.RTC_BUS = 8'h45; cyc();
    pif.LL_signal = 1'b0; pif.id_port = IDB + 8'd2; cyc();
    chk("cap_reg2", pif.dato_inpico, 8'h45);
    pif.LL_signal = 1'b1; pif.reg_select = 4'd12; pif.RTC_BUS = 8'hEE; cyc();
    pif.LL_signal = 1'b0; cyc(); cyc();
    chk("cap_sel12_reg2", pif.dato_inpico, 8'h45);
    for (int i = 0; i < NREG; i++) begin
      pif.id_port = IDB + 8'(i); cyc(); cyc();
      chk("cap_sel12_all", pif.dato_inpico, (i == 2) ? 8'h45 : 8'h00);
    end

    // Two pushes, two pops, a pop of an empty FIFO, then status.
    pif.id_port = 8'hFF;
    pif.tecla_valid = 1'b1; pif.tecla = 8'h0A; cyc();
    pif.tecla = 8'h0B; cyc();
    pif.tecla_valid = 1'b0; pif.id_port = IDK; pif.read_strobe = 1'b1; cyc();
    chk("pop_first", pif.dato_inpico, 8'h0A); cyc();
    chk("pop_second", pif.dato_inpico, 8'h0B); cyc();
    chk("pop_empty", pif.dato_inpico, 8'h00);
    pif.read_strobe = 1'b0; pif.id_port = IDS; cyc(); cyc();
    chk("status_empty", pif.dato_inpico, 8'h20);

    // Five pushes into depth 4: full, overflow, status C4; status read clears.
    pif.id_port = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      keys[i] = 8'(8'h50 + i);
      pif.tecla_valid = 1'b1; pif.tecla = keys[i]; cyc();
    end
    pif.tecla_valid = 1'b0; pif.id_port = IDS; cyc();
    chk("ovf_full", 8'(pif.key_full), 8'h01);
    chk("ovf_flag", 8'(pif.key_overflow), 8'h01);
    chk("ovf_status", pif.dato_inpico, 8'hC4);
    pif.read_strobe = 1'b1; cyc();
    pif.read_strobe = 1'b0; cyc();
    chk("ovf_cleared", 8'(pif.key_overflow), 8'h00);

    // Full FIFO: push and pop together, then drain.
    pif.tecla_valid = 1'b1; pif.tecla = 8'h77; pif.id_port = IDK; pif.read_strobe = 1'b1; cyc();
    pif.tecla_valid = 1'b0;
    chk("pushpop_head", pif.dato_inpico, keys[0]);
    chk("pushpop_full", 8'(pif.key_full), 8'h01);
    chk("pushpop_ovf", 8'(pif.key_overflow), 8'h00);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("drain", pif.dato_inpico, keys[i]);
    end
    cyc();
    chk("drain_77", pif.dato_inpico, 8'h77);
    pif.read_strobe = 1'b0; pif.id_port = IDS; cyc(); cyc();
    chk("drain_status", pif.dato_inpico, 8'h20);

    // Snapshot behaviour of register 1.
    pif.id_port = 8'hFF;
    pif.LL_signal = 1'b1; pif.reg_select = 4'd1; pif.RTC_BUS = 8'h30; cyc();
    pif.LL_signal = 1'b0; pif.id_port = IDB; pif.read_strobe = 1'b1; cyc();
    pif.read_strobe = 1'b0; pif.id_port = 8'hFF;
    pif.LL_signal = 1'b1; pif.RTC_BUS = 8'h31; cyc();
    pif.LL_signal = 1'b0; pif.id_port = IDB + 8'd1; cyc(); cyc();
`ifdef ENTRADA_PICO_SNAPSHOT_EN
    chk("snap_reg1", pif.dato_inpico, 8'h30);
`else
    chk("snap_reg1", pif.dato_inpico, 8'h31);
`endif

    // Reset mid-operation with three keys queued.
    pif.id_port = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      pif.tecla_valid = 1'b1; pif.tecla = 8'(8'h60 + i); cyc();
    end
    pif.tecla_valid = 1'b0; pif.id_port = IDS; cyc();
    chk("pre_reset_status", pif.dato_inpico, 8'h03);
    #2 reset = 1'b0;
    #1 chk("mid_reset_dato", pif.dato_inpico, 8'h00);
    chk("mid_reset_full", 8'(pif.key_full), 8'h00);
    cyc();
    #2 reset = 1'b1;
    cyc();
    chk("post_reset_status", pif.dato_inpico, 8'h20);
    pif.id_port = 8'hFF; pif.tecla_valid = 1'b1; pif.tecla = 8'h22; cyc();
    pif.tecla_valid = 1'b0; pif.id_port = IDK; pif.read_strobe = 1'b1; cyc();
    pif.read_strobe = 1'b0;
    chk("post_reset_key", pif.dato_inpico, 8'h22);

    // Randomized traffic, with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      pif.LL_signal   = ($urandom_range(0, 2) == 0);
      pif.reg_select  = 4'($urandom_range(0, 15));
      pif.RTC_BUS     = 8'($urandom);
      pif.tecla_valid = ($urandom_range(0, 1) == 1);
      pif.tecla       = 8'($urandom);
      pif.read_strobe = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r < 6)       pif.id_port = 8'($urandom_range(0, 9));
      else if (r < 8)  pif.id_port = IDK;
      else if (r == 8) pif.id_port = IDS;
      else             pif.id_port = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        cyc();
        #2 reset = 1'b1;
      end
      cyc();
    end

    idle();
    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
